// File: rtl/cnt60_down_timer.sv
// rtl/cnt60_down_timer.sv - BCD MM:SS countdown timer with load validation and expiry alarm
module cnt60_down_timer (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] set_min_h,
  input  logic [3:0] set_min_l,
  input  logic [3:0] set_sec_h,
  input  logic [3:0] set_sec_l,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0] state, state_nxt;
  logic [3:0] min_h_nxt, min_l_nxt, sec_h_nxt, sec_l_nxt;
  logic       done_nxt, load_err_nxt;
  logic       set_valid, is_zero, is_one;

  assign set_valid = (set_min_h <= 4'd5) && (set_min_l <= 4'd9) &&
                     (set_sec_h <= 4'd5) && (set_sec_l <= 4'd9);
  assign is_zero   = (min_h == 4'd0) && (min_l == 4'd0) &&
                     (sec_h == 4'd0) && (sec_l == 4'd0);
  assign is_one    = (min_h == 4'd0) && (min_l == 4'd0) &&
                     (sec_h == 4'd0) && (sec_l == 4'd1);

  // Next-state/next-value: load beats stop beats start beats tick
  always_comb begin
    state_nxt    = state;
    min_h_nxt    = min_h;
    min_l_nxt    = min_l;
    sec_h_nxt    = sec_h;
    sec_l_nxt    = sec_l;
    done_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (set_valid) begin
        min_h_nxt = set_min_h;
        min_l_nxt = set_min_l;
        sec_h_nxt = set_sec_h;
        sec_l_nxt = set_sec_l;
        state_nxt = ST_IDLE;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (stop) begin
      if (state == ST_RUN)
        state_nxt = ST_PAUSE;
      else if (state == ST_EXPIRED)
        state_nxt = ST_IDLE;
    end else if (start) begin
      // Starting from 00:00 would underflow on the first tick, so it is refused
      if ((state == ST_IDLE && !is_zero) || state == ST_PAUSE)
        state_nxt = ST_RUN;
    end else if (tick && state == ST_RUN) begin
      if (sec_l != 4'd0) begin
        sec_l_nxt = sec_l - 4'd1;
      end else begin
        sec_l_nxt = 4'd9;
        if (sec_h != 4'd0) begin
          sec_h_nxt = sec_h - 4'd1;
        end else begin
          sec_h_nxt = 4'd5;
          if (min_l != 4'd0) begin
            min_l_nxt = min_l - 4'd1;
          end else begin
            min_l_nxt = 4'd9;
            min_h_nxt = min_h - 4'd1;
          end
        end
      end
      if (is_one) begin
        state_nxt = ST_EXPIRED;
        done_nxt  = 1'b1;
      end
    end
  end

  // State, digits and flags are all registered; flags follow the next state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      min_h    <= 4'd0;
      min_l    <= 4'd0;
      sec_h    <= 4'd0;
      sec_l    <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_h    <= min_h_nxt;
      min_l    <= min_l_nxt;
      sec_h    <= sec_h_nxt;
      sec_l    <= sec_l_nxt;
      running  <= (state_nxt == ST_RUN);
      done     <= done_nxt;
      alarm    <= (state_nxt == ST_EXPIRED);
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: doc/cnt60_down_timer.md
# cnt60_down_timer

BCD minutes:seconds countdown timer for the clock design: the counting-down counterpart to the up-counting minute/second chain. It is loaded with an MM:SS value and decrements once per `tick` while running. At 00:00 it asserts an alarm. It sits beside the up-counters, shares the same 1 Hz tick source, and drives the same BCD display mux.

## Interface
Parameters: none.

- `clk`  in  1  system clock
- `clr`  in  1  reset, asynchronous, active-high
- `tick`  in  1  one-`clk`-cycle enable pulse, nominally 1 Hz
- `load`  in  1  pulse; capture `set_*` digits
- `set_min_h`, `set_min_l`, `set_sec_h`, `set_sec_l`  in  4 each  BCD preset value
- `start`  in  1  pulse; begin or resume counting
- `stop`  in  1  pulse; pause counting, or acknowledge the alarm
- `min_h`, `min_l`, `sec_h`, `sec_l`  out  4 each  current BCD value, registered
- `running`  out  1  high in RUN
- `done`  out  1  one-cycle pulse when the count reaches 00:00
- `alarm`  out  1  level, high in EXPIRED
- `load_err`  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values: all digits 0, state IDLE, `running`/`done`/`alarm`/`load_err` 0.
- States:
  - IDLE: stopped; value is loadable.
  - RUN: decrementing on `tick`.
  - PAUSE: frozen mid-count.
  - EXPIRED: reached 00:00; `alarm`=1.
- Input priority each cycle: `clr` > `load` > `stop` > `start` > `tick`.
- Load validation:
  - Valid when `set_min_h`≤5, `set_min_l`≤9, `set_sec_h`≤5, `set_sec_l`≤9.
  - Valid `load` in any state: digits take the preset and state goes to IDLE.
  - Invalid `load`: digits and state are unchanged; `load_err` pulses.
- Transitions:
  - IDLE + `start`, value ≠ 00:00 → RUN.
  - IDLE + `start`, value = 00:00 → start is ignored; stay IDLE.
  - RUN + `stop` → PAUSE.
  - PAUSE + `start` → RUN.
  - RUN + `tick`, value = 00:01 → value becomes 00:00, state goes to EXPIRED, `done` pulses.
  - EXPIRED + `stop` → IDLE; value stays 00:00 and `alarm` drops.
  - EXPIRED + `start` → ignored.
  - `tick` outside RUN → ignored.
- Decrement, applied only in RUN on `tick`:
  - `sec_l` 0→9 borrows from `sec_h`.
  - `sec_h` 0→5 borrows from `min_l`.
  - `min_l` 0→9 borrows from `min_h`.
  - `min_h` decrements by 1.
  - The count never wraps below 00:00 (RUN is never entered with 00:00).
- Digits remain valid BCD at all times. No arithmetic outside 4 bits per digit.

## Timing
- All outputs are registered; every effect is visible on the `clk` edge after the input is sampled.
- `load`: new digits and IDLE appear 1 cycle later. `load_err` is high for exactly that one cycle.
- `tick` in RUN: decremented value appears 1 cycle later.
- `done` is high for exactly the one cycle in which 00:00 first appears. `alarm` and the fall of `running` occur on that same edge.
- Simultaneous events:
  - `stop`+`tick` in RUN: PAUSE, no decrement.
  - `start`+`tick` in IDLE/PAUSE: RUN, no decrement that cycle.
  - `load`+`tick` in RUN: the load wins and the decrement is lost.
  - `start`+`stop`: `stop` wins.
- `clr` mid-count: all digits and flags go to 0 and state to IDLE immediately (asynchronously), with no `done` pulse.
- Back-to-back `tick` on consecutive cycles must each decrement; there is no minimum spacing.

## Test plan
- Reset, then load 01:00, `start`, one `tick` → 00:59; `running`=1, `done`=0.
- Load 00:02, `start`, two `tick` → 00:01, then 00:00 with `done` high one cycle, `alarm`=1, `running`=0. A further `start` changes nothing; `stop` → `alarm`=0, IDLE.
- Load 10:00, `start`, `stop` and `tick` in the same cycle → value stays 10:00, PAUSE. `start`, `tick` → 09:59.
- Load with `set_sec_h`=6 (00:6A-style) → `load_err` pulses one cycle; previous value and state are retained. Load 00:00, then `start` → stays IDLE.
- Load 59:59, `start`, 3599 ticks → value steps through all BCD digits down to 00:00, with exactly one `done` pulse at the end.
- Assert `clr` asynchronously mid-RUN at 05:30 → all outputs 0 and IDLE before the next edge; no `done`/`alarm`.
